// File: rtl/fft_out_serializer_if.sv
// Output stream bundle of the FFT serializer: one scaled complex bin per beat.
interface fft_out_serializer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 5
);
  logic                         m_valid;
  logic                         m_ready;
  logic signed [DATA_WIDTH-1:0] m_real;
  logic signed [DATA_WIDTH-1:0] m_imag;
  logic [2*DATA_WIDTH-1:0]      m_data;
  logic [IDX_WIDTH-1:0]         m_bin;
  logic                         m_last;

  modport master (
    output m_valid, m_real, m_imag, m_data, m_bin, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_real, m_imag, m_data, m_bin, m_last,
    output m_ready
  );
endinterface

// File: rtl/fft_out_serializer.sv
// Ping-pong capture of parallel FFT frames, scaled by an arithmetic shift and
// streamed out one bin per valid/ready beat.
module fft_out_serializer #(
  parameter int N          = 32,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_SHIFT  = 3,
  parameter int IDX_WIDTH  = $clog2(N)
) (
  input  logic                    clk_100mhz,
  input  logic                    rst_n,
  input  logic                    fft_out_valid,
  input  logic [N*DATA_WIDTH-1:0] fft_real_flat,
  input  logic [N*DATA_WIDTH-1:0] fft_imag_flat,
  output logic                    frame_ready,
  fft_out_serializer_if.master    m_if,
  output logic [7:0]              drop_count
);

  localparam logic [IDX_WIDTH-1:0] LAST_BIN = IDX_WIDTH'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  function automatic logic signed [DATA_WIDTH-1:0] scale(input logic signed [DATA_WIDTH-1:0] x);
    return x >>> OUT_SHIFT;
  endfunction

  state_t                       state_q, state_d;
  logic                         vld_prev_q, vld_prev_d;
  logic [1:0]                   full_q, full_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic [IDX_WIDTH-1:0]         bin_q, bin_d;
  logic [7:0]                   drop_q, drop_d;
  logic                         last_q, last_d;
  logic signed [DATA_WIDTH-1:0] real_q, real_d;
  logic signed [DATA_WIDTH-1:0] imag_q, imag_d;
  logic signed [DATA_WIDTH-1:0] bank_real_q [2][N];
  logic signed [DATA_WIDTH-1:0] bank_real_d [2][N];
  logic signed [DATA_WIDTH-1:0] bank_imag_q [2][N];
  logic signed [DATA_WIDTH-1:0] bank_imag_d [2][N];

  logic capture, wr_en, drop_inc, release_bank;

  // Capture side: edge-detect the core's valid level, fill the write bank if free.
  assign capture  = fft_out_valid & ~vld_prev_q;
  assign wr_en    = capture & ~full_q[wr_ptr_q];
  assign drop_inc = capture &  full_q[wr_ptr_q];

  always_comb begin
    vld_prev_d  = fft_out_valid;
    wr_ptr_d    = wr_ptr_q ^ wr_en;
    drop_d      = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    bank_real_d = bank_real_q;
    bank_imag_d = bank_imag_q;
    if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        bank_real_d[wr_ptr_q][k] = fft_real_flat[k*DATA_WIDTH +: DATA_WIDTH];
        bank_imag_d[wr_ptr_q][k] = fft_imag_flat[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    // A bank released by the final beat is only seen as empty from the next cycle.
    full_d = full_q;
    if (release_bank) full_d[rd_ptr_q] = 1'b0;
    if (wr_en)        full_d[wr_ptr_q] = 1'b1;
  end

  // Read FSM: state register
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Read FSM: next state, bin and bank pointer
  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    rd_ptr_d     = rd_ptr_q;
    release_bank = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full_q[rd_ptr_q]) begin
          state_d = STREAM;
          bin_d   = '0;
        end
      end
      STREAM: begin
        if (m_if.m_ready) begin
          if (bin_q != LAST_BIN) begin
            bin_d = bin_q + IDX_WIDTH'(1);
          end else begin
            release_bank = 1'b1;
            rd_ptr_d     = ~rd_ptr_q;
            bin_d        = '0;
            state_d      = full_q[~rd_ptr_q] ? STREAM : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read FSM: registered beat contents follow the next bin, so they hold under backpressure
  always_comb begin
    real_d = '0;
    imag_d = '0;
    last_d = 1'b0;
    if (state_d == STREAM) begin
      real_d = scale(bank_real_q[rd_ptr_d][bin_d]);
      imag_d = scale(bank_imag_q[rd_ptr_d][bin_d]);
      last_d = (bin_d == LAST_BIN);
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      vld_prev_q <= 1'b0;
      full_q     <= 2'b00;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      bin_q      <= '0;
      drop_q     <= '0;
      last_q     <= 1'b0;
      real_q     <= '0;
      imag_q     <= '0;
    end else begin
      vld_prev_q <= vld_prev_d;
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      bin_q      <= bin_d;
      drop_q     <= drop_d;
      last_q     <= last_d;
      real_q     <= real_d;
      imag_q     <= imag_d;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    bank_real_q <= bank_real_d;
    bank_imag_q <= bank_imag_d;
  end

  assign frame_ready    = ~full_q[0] | ~full_q[1];
  assign drop_count     = drop_q;
  assign m_if.m_valid   = (state_q == STREAM);
  assign m_if.m_bin     = bin_q;
  assign m_if.m_last    = last_q;
  assign m_if.m_real    = real_q;
  assign m_if.m_imag    = imag_q;
  assign m_if.m_data    = {real_q, imag_q};

endmodule
